line_doubler: RTL

Scan doubler that sits directly downstream of the beam counter and colour/pixel path. It captures each 15 kHz input line (RGB, blanking and horizontal sync) into a ping-pong line buffer and replays the previous line twice at double pixel rate, producing 31 kHz VGA-compatible video. A bypass mode passes 15 kHz video through with one register stage.

---
 rtl/line_doubler_pkg.sv | 24 ++
 rtl/line_doubler_ram.sv | 30 +++
 rtl/line_doubler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/line_doubler_pkg.sv
// rtl/line_doubler_pkg.sv - shared video constants, stored-word layout and read-state encodings
package line_doubler_pkg;

  localparam int LBUF_AW_DEF = 10;
  localparam int PIX_W_DEF   = 14;

  // Stored word: {_hsync, blank, red[3:0], green[3:0], blue[3:0]}
  localparam int HS_BIT = 13;
  localparam int BL_BIT = 12;
  localparam int R_MSB  = 11;
  localparam int G_MSB  = 7;
  localparam int B_MSB  = 3;

  // Blank pixel: hsync inactive (high), blank asserted, black
  localparam logic [PIX_W_DEF-1:0] PIX_BLANK = {1'b1, 1'b1, 12'h000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/line_doubler_ram.sv
// rtl/line_doubler_ram.sv - simple dual-port line buffer RAM with registered read port
module line_doubler_ram #(
  parameter int AW = 11,
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its data while re is low
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_doubler.sv
// rtl/line_doubler.sv - scan doubler: captures 15 kHz lines, replays each twice at 31 kHz, or bypasses
module line_doubler
  import line_doubler_pkg::*;
#(
  parameter int LBUF_AW = LBUF_AW_DEF,
  parameter int PIX_W   = PIX_W_DEF
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       en2x,
  input  logic       eol,
  input  logic       pix_in_en,
  input  logic       pix_out_en,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  input  logic       _hsync_in,
  input  logic       _vsync_in,
  input  logic       blank_in,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out,
  output logic       _hsync_out,
  output logic       _vsync_out,
  output logic       blank_out
);

  localparam logic [LBUF_AW-1:0] ADDR_MAX = '1;
  localparam logic [LBUF_AW-1:0] ADDR_ONE = {{(LBUF_AW-1){1'b0}}, 1'b1};

  // Write side state
  logic               wr_bank_q, wr_bank_d;
  logic [LBUF_AW-1:0] wr_addr_q, wr_addr_d;
  logic [LBUF_AW-1:0] line_len_q, line_len_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               seen_q, seen_d;

  // Read side state
  rd_state_e          state_q, state_d;
  logic [LBUF_AW-1:0] rd_addr_q, rd_addr_d;
  logic               vs_pass_q, vs_pass_d;

  // Read pipeline stage aligned with RAM data, then output register
  logic               act_p1_q, act_p1_d;
  logic               vs_p1_q, vs_p1_d;
  logic [PIX_W-1:0]   out_q, out_d;
  logic               vs_out_q, vs_out_d;

  logic               wr_en;
  logic               rd_last;
  logic               rd_active;
  logic [PIX_W-1:0]   wdata;
  logic [PIX_W-1:0]   rdata;

  assign wdata = {_hsync_in, blank_in, red_in, green_in, blue_in};
  // Pixels past the last address are dropped rather than overwriting it
  assign wr_en = pix_in_en && (wr_addr_q != ADDR_MAX);

  line_doubler_ram #(
    .AW (LBUF_AW + 1),
    .DW (PIX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank_q, wr_addr_q}),
    .wdata (wdata),
    .re    (pix_out_en),
    .raddr ({~wr_bank_q, rd_addr_q}),
    .rdata (rdata)
  );

  // Write address, bank swap and per-line bookkeeping at end of line
  always_comb begin
    wr_addr_d  = wr_addr_q;
    wr_bank_d  = wr_bank_q;
    line_len_d = line_len_q;
    mode_d     = mode_q;
    valid_d    = valid_q;
    seen_d     = seen_q;
    if (wr_en) wr_addr_d = wr_addr_q + ADDR_ONE;
    if (eol) begin
      wr_addr_d  = '0;
      wr_bank_d  = ~wr_bank_q;
      line_len_d = wr_en ? (wr_addr_q + ADDR_ONE) : wr_addr_q;
      mode_d     = en2x;
      valid_d    = seen_q;
      seen_d     = 1'b1;
    end
  end

  assign rd_last   = (line_len_q == '0) || (rd_addr_q == (line_len_q - ADDR_ONE));
  assign rd_active = valid_q && (line_len_q != '0) && (state_q inside {PASS0, PASS1});

  // Read FSM: two passes over the previous line, restarted by every eol
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    vs_pass_d = vs_pass_q;
    if (eol) begin
      state_d   = PASS0;
      rd_addr_d = '0;
      vs_pass_d = _vsync_in;
    end else if (pix_out_en && (state_q inside {PASS0, PASS1})) begin
      if (rd_last) begin
        rd_addr_d = '0;
        if (state_q == PASS0) begin
          state_d   = PASS1;
          vs_pass_d = _vsync_in;
        end else begin
          state_d = DONE;
        end
      end else begin
        rd_addr_d = rd_addr_q + ADDR_ONE;
      end
    end
  end

  // Pipeline control alongside RAM data, and the output register
  always_comb begin
    act_p1_d = act_p1_q;
    vs_p1_d  = vs_p1_q;
    out_d    = out_q;
    vs_out_d = vs_out_q;
    if (pix_out_en) begin
      act_p1_d = rd_active;
      vs_p1_d  = vs_pass_q;
    end
    if (!mode_q) begin
      out_d    = wdata;
      vs_out_d = _vsync_in;
    end else if (pix_out_en) begin
      out_d    = act_p1_q ? rdata : PIX_BLANK;
      vs_out_d = vs_p1_q;
    end
  end

  // Write side registers
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      wr_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      line_len_q <= '0;
      mode_q     <= 1'b0;
      valid_q    <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      wr_bank_q  <= wr_bank_d;
      line_len_q <= line_len_d;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      seen_q     <= seen_d;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      vs_pass_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      vs_pass_q <= vs_pass_d;
    end
  end

  // Pipeline and output registers
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      act_p1_q <= 1'b0;
      vs_p1_q  <= 1'b1;
      out_q    <= PIX_BLANK;
      vs_out_q <= 1'b1;
    end else begin
      act_p1_q <= act_p1_d;
      vs_p1_q  <= vs_p1_d;
      out_q    <= out_d;
      vs_out_q <= vs_out_d;
    end
  end

  assign red_out    = out_q[R_MSB -: 4];
  assign green_out  = out_q[G_MSB -: 4];
  assign blue_out   = out_q[B_MSB -: 4];
  assign _hsync_out = out_q[HS_BIT];
  assign blank_out  = out_q[BL_BIT];
  assign _vsync_out = vs_out_q;

endmodule
